interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 10 +
 rtl/interrupt_controller_priority_enc.sv | 13 +
 rtl/interrupt_controller.sv | 65 ++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared constants, FSM encoding and vector-address helper.
package interrupt_controller_pkg;
    localparam int NUM_IRQ = 4;
    localparam int ID_W = $clog2(NUM_IRQ);
    localparam logic [15:0] VECTOR_BASE = 16'h0F00;
    typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, SERVICE = 2'd2} ctrlState;
    function automatic logic [15:0] vectorAddr(input logic [ID_W-1:0] id);
        return VECTOR_BASE + 16'({id, 3'b000});
    endfunction
endpackage

// File: rtl/interrupt_controller_priority_enc.sv
// irq_priority_enc: lowest-index-wins priority encoder over the eligible request vector.
module irq_priority_enc
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);
    always_comb begin
        valid = |req;
        idx = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-captured, maskable, non-nesting interrupt controller with vectored handler address.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    input  logic [NUM_IRQ-1:0]  IRQ,
    input  logic                MaskWrite,
    input  logic [NUM_IRQ-1:0]  MaskData,
    input  logic                EPCWrite,
    input  logic                CLR,
    output logic                InterruptIn,
    output logic                InterruptHandler,
    output logic [ID_W-1:0]     IntID,
    output logic [15:0]         HandlerAddr,
    output logic [NUM_IRQ-1:0]  Pending
);
    ctrlState state, nextState;
    logic [NUM_IRQ-1:0] irqPrev, mask, eligible, irqEdge, clearMask, pendingNext;
    logic winValid, accept;
    logic [ID_W-1:0] winIdx;
    assign irqEdge = IRQ & ~irqPrev;
    assign eligible = Pending & mask;
    irq_priority_enc uEnc (
        .req(eligible),
        .valid(winValid),
        .idx(winIdx)
    );
    always_comb begin
        nextState = state;
        accept = 1'b0;
        case (state)
            IDLE:    nextState = winValid ? REQUEST : IDLE;
            REQUEST: begin
                accept = EPCWrite && winValid;
                nextState = !winValid ? IDLE : EPCWrite ? SERVICE : REQUEST;
            end
            SERVICE: nextState = CLR ? IDLE : SERVICE;
            default: nextState = IDLE;
        endcase
        clearMask = accept ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << winIdx) : '0;
        // a fresh edge on the bit being accepted wins over its clear
        pendingNext = (Pending & ~clearMask) | irqEdge;
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            irqPrev <= '0;
            mask <= '0;
            Pending <= '0;
            IntID <= '0;
            InterruptIn <= 1'b0;
            InterruptHandler <= 1'b0;
        end else begin
            state <= nextState;
            irqPrev <= IRQ;
            Pending <= pendingNext;
            InterruptIn <= nextState == REQUEST;
            InterruptHandler <= nextState == SERVICE;
            if (MaskWrite) mask <= MaskData;
            if (accept) IntID <= winIdx;
        end
    end
    assign HandlerAddr = Reset ? VECTOR_BASE : vectorAddr(IntID);
endmodule
